// File: rtl/conv_pkg.sv
// Shared types and helpers for the 5x5 convolution frame sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH  = 320;
  localparam int unsigned DEF_HEIGHT = 240;
  localparam int unsigned DEF_K      = 5;

  // Kernel window centred at (col,row) reaches outside the frame
  function automatic logic is_border(input int unsigned col, input int unsigned row,
                                     input int unsigned width, input int unsigned height,
                                     input int unsigned r);
    return (col < r) || (col >= width - r) || (row < r) || (row >= height - r);
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Column/row position counter with raster wrap; clear and advance may combine
// (clear+advance lands on position 1).
module conv_pos_counter #(
  parameter int unsigned W  = 8,
  parameter int unsigned H  = 8,
  parameter int unsigned CW = 3,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_first,
  output logic          o_last
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col_base;
  logic [RW-1:0] w_row_base;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;

  always_comb begin
    w_col_base = i_clr ? '0 : r_col;
    w_row_base = i_clr ? '0 : r_row;
    w_col_nxt  = w_col_base;
    w_row_nxt  = w_row_base;
    if (i_en) begin
      if (w_col_base == CW'(W - 1)) begin
        w_col_nxt = '0;
        w_row_nxt = (w_row_base == RW'(H - 1)) ? '0 : w_row_base + RW'(1);
      end else begin
        w_col_nxt = w_col_base + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  assign o_col   = r_col;
  assign o_row   = r_row;
  assign o_first = (r_col == '0) && (r_row == '0);
  assign o_last  = (r_col == CW'(W - 1)) && (r_row == RW'(H - 1));

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the KxK blur datapath: handshake, priming, flush, border tags.
// Optional CONV_CTRL_STATS_EN adds saturating frame_cnt / err_cnt outputs.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned K      = DEF_K
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  output logic                      in_ready,
  output logic                      shift_en,
  output logic                      inject_zero,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_border,
  output logic [$clog2(WIDTH)-1:0]  out_col,
  output logic [$clog2(HEIGHT)-1:0] out_row,
`ifdef CONV_CTRL_STATS_EN
  output logic                      err_sync,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               err_cnt
`else
  output logic                      err_sync
`endif
);

  localparam int unsigned R       = K / 2;
  localparam int unsigned D       = R * WIDTH + R;
  localparam int unsigned CW      = $clog2(WIDTH);
  localparam int unsigned RW      = $clog2(HEIGHT);
  localparam int unsigned DM1_COL = (D - 1) % WIDTH;
  localparam int unsigned DM1_ROW = (D - 1) / WIDTH;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_in_ready;
  logic          w_shift;
  logic          w_inject;
  logic          w_emit;
  logic          w_in_clr;
  logic          w_in_en;
  logic          w_out_clr;
  logic          w_err;
  logic          w_acc;
  logic          w_in_at_dm1;
  logic [CW-1:0] w_in_col;
  logic [RW-1:0] w_in_row;
  logic          w_in_last;
  logic          w_unused_in_first;
  logic [CW-1:0] w_out_col;
  logic [RW-1:0] w_out_row;
  logic          w_out_first;
  logic          w_out_last;

  logic          r_out_valid;
  logic          r_out_sop;
  logic          r_out_eop;
  logic          r_out_border;
  logic [CW-1:0] r_out_col;
  logic [RW-1:0] r_out_row;
  logic          r_err_sync;

  // Input counter holds the index of the next pixel; during FLUSH it counts flush cycles
  conv_pos_counter #(.W(WIDTH), .H(HEIGHT), .CW(CW), .RW(RW)) u_in_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_in_clr),
    .i_en    (w_in_en),
    .o_col   (w_in_col),
    .o_row   (w_in_row),
    .o_first (w_unused_in_first),
    .o_last  (w_in_last)
  );

  conv_pos_counter #(.W(WIDTH), .H(HEIGHT), .CW(CW), .RW(RW)) u_out_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_out_clr),
    .i_en    (w_emit),
    .o_col   (w_out_col),
    .o_row   (w_out_row),
    .o_first (w_out_first),
    .o_last  (w_out_last)
  );

  assign w_acc       = in_valid & out_ready;
  assign w_in_at_dm1 = (w_in_col == CW'(DM1_COL)) && (w_in_row == RW'(DM1_ROW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_shift     = 1'b0;
    w_inject    = 1'b0;
    w_emit      = 1'b0;
    w_in_clr    = 1'b0;
    w_in_en     = 1'b0;
    w_out_clr   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid && in_sop) begin
          w_shift     = 1'b1;
          w_in_clr    = 1'b1;
          w_in_en     = 1'b1;
          w_out_clr   = 1'b1;
          w_err       = in_eop;
          w_state_nxt = PRIME;
        end
      end
      PRIME, RUN: begin
        w_in_ready = out_ready;
        if (w_acc) begin
          w_shift = 1'b1;
          w_in_en = 1'b1;
          if (in_sop) begin
            // Resync: this pixel starts a fresh frame
            w_err       = 1'b1;
            w_in_clr    = 1'b1;
            w_out_clr   = 1'b1;
            w_state_nxt = PRIME;
          end else begin
            w_err  = in_eop & ~w_in_last;
            w_emit = (r_state == RUN);
            if (r_state == PRIME && w_in_at_dm1) w_state_nxt = RUN;
            if (r_state == RUN && w_in_last)     w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_ready) begin
          w_shift  = 1'b1;
          w_inject = 1'b1;
          w_emit   = 1'b1;
          if (w_in_at_dm1) begin
            w_in_clr    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_in_en = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output register stage; holds everything while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_border <= 1'b0;
      r_out_col    <= '0;
      r_out_row    <= '0;
      r_err_sync   <= 1'b0;
    end else begin
      if (w_err) r_err_sync <= 1'b1;
      if (out_ready) begin
        r_out_valid  <= w_emit;
        r_out_sop    <= w_emit & w_out_first;
        r_out_eop    <= w_emit & w_out_last;
        r_out_border <= w_emit & is_border(32'(w_out_col), 32'(w_out_row), WIDTH, HEIGHT, R);
        r_out_col    <= w_out_col;
        r_out_row    <= w_out_row;
      end
    end
  end

  // Combinational strobes are forced low while reset is asserted
  assign in_ready    = rst_n & w_in_ready;
  assign shift_en    = rst_n & w_shift;
  assign inject_zero = rst_n & w_inject;
  assign out_valid   = r_out_valid;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_border  = r_out_border;
  assign out_col     = r_out_col;
  assign out_row     = r_out_row;
  assign err_sync    = r_err_sync;

`ifdef CONV_CTRL_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (r_out_valid && r_out_eop && out_ready && (r_frame_cnt != 16'hFFFF))
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule
